// File: rtl/ma_output_capture_pkg.sv
// Shared types and default sizing for the moving-average capture block.
// The filter bench imports the same constants so both sides agree on widths.
package ma_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } ma_cap_state_t;

    localparam int MA_DATA_WIDTH = 16;
    localparam int MA_DEPTH      = 512;

endpackage

// File: rtl/ma_output_capture_if.sv
// Sample stream from the filter plus the buffer readback port.
// master = filter/host side, slave = capture block.
interface ma_output_capture_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9
);
    logic [DATA_WIDTH-1:0] MA_data_out;
    logic                  MA_data_out_ready;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;

    modport master (
        output MA_data_out,
        output MA_data_out_ready,
        output rd_en,
        output rd_addr,
        input  rd_data,
        input  rd_valid
    );

    modport slave (
        input  MA_data_out,
        input  MA_data_out_ready,
        input  rd_en,
        input  rd_addr,
        output rd_data,
        output rd_valid
    );
endinterface

// File: rtl/ma_output_capture_ram.sv
// Simple dual-port synchronous RAM, one write port and one registered read port.
// Read and write share one process so a same-address read returns the old word.
module ma_capture_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    localparam int WORDS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [WORDS];
    logic [DATA_WIDTH-1:0] rd_data_reg;

    // No reset on the array or its output register so the tools map it to block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;
endmodule

// File: rtl/ma_output_capture.sv
// Captures the filter output stream into a DEPTH-word buffer, tracks signed
// min/max of the current capture, and serves gated readback of captured words.
module ma_output_capture
    import ma_capture_pkg::*;
#(
    parameter int DATA_WIDTH = MA_DATA_WIDTH,
    parameter int DEPTH      = MA_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    arm,
    ma_output_capture_if.slave      cap_if,
    output logic [ADDR_WIDTH:0]     sample_count,
    output logic                    busy,
    output logic                    capture_done,
    output logic                    overflow,
    output logic [DATA_WIDTH-1:0]   min_sample,
    output logic [DATA_WIDTH-1:0]   max_sample
);
    localparam logic [ADDR_WIDTH:0] LAST_COUNT = (ADDR_WIDTH + 1)'(DEPTH - 1);

    ma_cap_state_t         state_reg;
    logic [ADDR_WIDTH:0]   count_reg;
    logic [DATA_WIDTH-1:0] min_reg;
    logic [DATA_WIDTH-1:0] max_reg;
    logic                  overflow_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic                  rd_valid_reg;
    logic                  rd_in_range_reg;

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] ram_rd_data;
    logic signed [DATA_WIDTH-1:0] sample_s;

    // arm takes priority over a coincident strobe, so the sample is never written.
    assign wr_en    = cap_if.MA_data_out_ready && !arm && (state_reg == CAPTURE);
    assign sample_s = $signed(cap_if.MA_data_out);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            min_reg      <= '0;
            max_reg      <= '0;
            overflow_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else if (arm) begin
            state_reg    <= CAPTURE;
            count_reg    <= '0;
            min_reg      <= '0;
            max_reg      <= '0;
            overflow_reg <= 1'b0;
            busy_reg     <= 1'b1;
            done_reg     <= 1'b0;
        end else begin
            case (state_reg)
                CAPTURE: begin
                    if (cap_if.MA_data_out_ready) begin
                        count_reg <= count_reg + 1'b1;
                        if (count_reg == '0) begin
                            min_reg <= cap_if.MA_data_out;
                            max_reg <= cap_if.MA_data_out;
                        end else begin
                            if (sample_s < $signed(min_reg)) min_reg <= cap_if.MA_data_out;
                            if (sample_s > $signed(max_reg)) max_reg <= cap_if.MA_data_out;
                        end
                        if (count_reg == LAST_COUNT) begin
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (cap_if.MA_data_out_ready) overflow_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Range test uses the count at request time; the RAM word is masked a cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_reg    <= 1'b0;
            rd_in_range_reg <= 1'b0;
        end else begin
            rd_valid_reg <= cap_if.rd_en;
            if (cap_if.rd_en) begin
                rd_in_range_reg <= ({1'b0, cap_if.rd_addr} < count_reg);
            end
        end
    end

    ma_capture_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (count_reg[ADDR_WIDTH-1:0]),
        .wr_data (cap_if.MA_data_out),
        .rd_en   (cap_if.rd_en),
        .rd_addr (cap_if.rd_addr),
        .rd_data (ram_rd_data)
    );

    assign cap_if.rd_data  = rd_in_range_reg ? ram_rd_data : '0;
    assign cap_if.rd_valid = rd_valid_reg;
    assign sample_count    = count_reg;
    assign busy            = busy_reg;
    assign capture_done    = done_reg;
    assign overflow        = overflow_reg;
    assign min_sample      = min_reg;
    assign max_sample      = max_reg;
endmodule

// File: tb/tb_ma_output_capture.sv
// Directed bench for ma_output_capture: reset, full ramp capture and readback,
// overflow, signed extremes, restart/collision and read timing.
module tb_ma_output_capture;
    import ma_capture_pkg::*;

    localparam int DW = 16;
    localparam int DEPTH = 512;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          arm;
    logic [AW:0]   sample_count;
    logic          busy;
    logic          capture_done;
    logic          overflow;
    logic [DW-1:0] min_sample;
    logic [DW-1:0] max_sample;

    int n_checks = 0;
    int n_errors = 0;

    ma_output_capture_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) cap_if ();

    ma_output_capture #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .arm          (arm),
        .cap_if       (cap_if.slave),
        .sample_count (sample_count),
        .busy         (busy),
        .capture_done (capture_done),
        .overflow     (overflow),
        .min_sample   (min_sample),
        .max_sample   (max_sample)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [DW-1:0] d);
        cap_if.MA_data_out       = d;
        cap_if.MA_data_out_ready = 1'b1;
        tick();
        cap_if.MA_data_out_ready = 1'b0;
    endtask

    task automatic check_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        cap_if.rd_en   = 1'b1;
        cap_if.rd_addr = a;
        tick();
        cap_if.rd_en = 1'b0;
        check({tag, "_valid"}, 32'(cap_if.rd_valid), 32'd1);
        check(tag, 32'(cap_if.rd_data), 32'(exp));
        $display("read addr=%0d data=0x%0h valid=%0b", a, cap_if.rd_data, cap_if.rd_valid);
    endtask

    initial begin
        reset_n                  = 1'b0;
        arm                      = 1'b0;
        cap_if.MA_data_out       = 16'h1234;
        cap_if.MA_data_out_ready = 1'b0;
        cap_if.rd_en             = 1'b0;
        cap_if.rd_addr           = '0;

        // Reset held with toggling strobe and read requests
        for (int i = 0; i < 6; i++) begin
            cap_if.MA_data_out_ready = ~cap_if.MA_data_out_ready;
            cap_if.rd_en             = 1'b1;
            tick();
        end
        cap_if.MA_data_out_ready = 1'b0;
        cap_if.rd_en             = 1'b0;
        check("rst_count", 32'(sample_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(capture_done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_min", 32'(min_sample), 32'd0);
        check("rst_max", 32'(max_sample), 32'd0);
        check("rst_rd_valid", 32'(cap_if.rd_valid), 32'd0);
        check("rst_rd_data", 32'(cap_if.rd_data), 32'd0);
        reset_n = 1'b1;

        // Strobes in IDLE are ignored
        for (int i = 0; i < 3; i++) strobe(16'(i + 7));
        check("idle_count", 32'(sample_count), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        $display("reset/idle: count=%0d busy=%0b", sample_count, busy);

        // Full ramp capture with random gaps
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("arm_busy", 32'(busy), 32'd1);
        check("arm_count", 32'(sample_count), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            strobe(16'(i));
            if (i == DEPTH - 1) begin
                check("full_done", 32'(capture_done), 32'd1);
                check("full_busy", 32'(busy), 32'd0);
            end else if (i == DEPTH - 2) begin
                check("full_not_done", 32'(capture_done), 32'd0);
            end
            if ($urandom_range(0, 1) == 1) tick();
        end
        check("full_count", 32'(sample_count), 32'd512);
        check("full_min", 32'(min_sample), 32'd0);
        check("full_max", 32'(max_sample), 32'd511);
        $display("full capture: count=%0d min=%0d max=%0d", sample_count, min_sample, max_sample);
        for (int i = 0; i < DEPTH; i++) begin
            cap_if.rd_en   = 1'b1;
            cap_if.rd_addr = AW'(i);
            tick();
            check("ramp_rd_valid", 32'(cap_if.rd_valid), 32'd1);
            check("ramp_rd_data", 32'(cap_if.rd_data), 32'(i));
        end
        cap_if.rd_en = 1'b0;
        tick();
        check("ramp_rd_valid_low", 32'(cap_if.rd_valid), 32'd0);

        // Overflow in DONE
        strobe(16'hBEEF);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_count", 32'(sample_count), 32'd512);
        tick();
        check("ovf_sticky", 32'(overflow), 32'd1);
        check_read("ovf_mem0", 9'd0, 16'h0000);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("ovf_clear", 32'(overflow), 32'd0);
        check("rearm_done", 32'(capture_done), 32'd0);
        check("rearm_busy", 32'(busy), 32'd1);

        // Signed extremes
        strobe(16'h7FFF);
        check("sx_first_min", 32'(min_sample), 32'h7FFF);
        check("sx_first_max", 32'(max_sample), 32'h7FFF);
        strobe(16'h8000);
        strobe(16'h0001);
        check("sx_count", 32'(sample_count), 32'd3);
        check("sx_min", 32'(min_sample), 32'h8000);
        check("sx_max", 32'(max_sample), 32'h7FFF);
        $display("signed: min=0x%0h max=0x%0h", min_sample, max_sample);

        // Restart after 100 samples, then arm colliding with a strobe
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 100; i++) strobe(16'(1000 + i));
        check("restart_pre_count", 32'(sample_count), 32'd100);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("restart_count", 32'(sample_count), 32'd0);
        check("restart_min", 32'(min_sample), 32'd0);
        arm = 1'b1;
        cap_if.MA_data_out       = 16'h5555;
        cap_if.MA_data_out_ready = 1'b1;
        tick();
        arm                      = 1'b0;
        cap_if.MA_data_out_ready = 1'b0;
        check("collide_count", 32'(sample_count), 32'd0);
        check("collide_max", 32'(max_sample), 32'd0);
        check_read("restart_rd5", 9'd5, 16'h0000);

        // Read timing: three back-to-back reads
        strobe(16'd20);
        strobe(16'd30);
        strobe(16'd40);
        strobe(16'd50);
        strobe(16'd60);
        tick();
        check("rt_idle_valid", 32'(cap_if.rd_valid), 32'd0);
        cap_if.rd_en   = 1'b1;
        cap_if.rd_addr = 9'd2;
        tick();
        check("rt_v0", 32'(cap_if.rd_valid), 32'd1);
        check("rt_d0", 32'(cap_if.rd_data), 32'd40);
        cap_if.rd_addr = 9'd3;
        tick();
        check("rt_v1", 32'(cap_if.rd_valid), 32'd1);
        check("rt_d1", 32'(cap_if.rd_data), 32'd50);
        cap_if.rd_addr = 9'd4;
        tick();
        check("rt_v2", 32'(cap_if.rd_valid), 32'd1);
        check("rt_d2", 32'(cap_if.rd_data), 32'd60);
        cap_if.rd_en = 1'b0;
        tick();
        check("rt_v_end", 32'(cap_if.rd_valid), 32'd0);
        $display("read timing: 3 back-to-back reads done");

        // Read of the word being written this cycle sees the pre-write view
        cap_if.rd_en             = 1'b1;
        cap_if.rd_addr           = 9'd5;
        cap_if.MA_data_out       = 16'd70;
        cap_if.MA_data_out_ready = 1'b1;
        tick();
        cap_if.MA_data_out_ready = 1'b0;
        check("coll_valid", 32'(cap_if.rd_valid), 32'd1);
        check("coll_old", 32'(cap_if.rd_data), 32'd0);
        tick();
        check("coll_new", 32'(cap_if.rd_data), 32'd70);
        cap_if.rd_en = 1'b0;
        check("coll_count", 32'(sample_count), 32'd6);
        $display("collision: count=%0d", sample_count);

        // Asynchronous reset mid-capture
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_count", 32'(sample_count), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_min", 32'(min_sample), 32'd0);
        check("arst_max", 32'(max_sample), 32'd0);
        check("arst_rd_valid", 32'(cap_if.rd_valid), 32'd0);
        tick();
        reset_n = 1'b1;
        check_read("arst_rd0", 9'd0, 16'h0000);
        $display("async reset: count=%0d busy=%0b", sample_count, busy);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
